// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy, programmable almost flags,
// sticky overflow/underflow errors and selectable standard/FWFT read mode.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  rd_ok;
    logic                  wr_ok;

    // Accept decisions use the registered flags from before the edge; a full
    // FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_ok     = read & ~empty;
        wr_ok     = write & (~full | rd_ok);
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RSTn) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_L);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_L);
            almost_empty <= (count_nxt <= AE_L);
            // A fresh error wins over a clear arriving in the same cycle.
            overflow     <= (write & ~wr_ok) | (overflow & ~clr_err);
            underflow    <= (read & empty) | (underflow & ~clr_err);
        end
    end

    // NOTE: storage is deliberately left out of reset so it can map onto RAM; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (RSTn && wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is presented directly; masked to zero while empty.
            assign rdata = empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge CLK) begin
                if (!RSTn)      rdata_q <= '0;
                else if (rd_ok) rdata_q <= mem[rptr[ADDR_WIDTH-1:0]];
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a standard-mode instance carries most
// vectors, a second FWFT instance covers fall-through behaviour.
module tb_sync_fifo_flags;

    logic       CLK = 1'b0;
    logic       RSTn;

    logic       write, read, clr_err;
    logic [7:0] wdata, rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_write, f_read, f_clr_err;
    logic [7:0] f_wdata, f_rdata;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
        .CLK(CLK), .RSTn(RSTn), .write(write), .read(read), .wdata(wdata), .clr_err(clr_err),
        .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .CLK(CLK), .RSTn(RSTn), .write(f_write), .read(f_read), .wdata(f_wdata), .clr_err(f_clr_err),
        .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        write = 1'b1;
        wdata = d;
        tick();
        write = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; write = 1'b1; read = 1'b1; wdata = 8'hFF; clr_err = 1'b0;
        f_write = 1'b0; f_read = 1'b0; f_wdata = 8'h00; f_clr_err = 1'b0;

        // Reset held with both requests active.
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);

        RSTn = 1'b1; write = 1'b0; read = 1'b0;
        tick();
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_ovf", 32'(overflow), 32'd0);
        check("idle_unf", 32'(underflow), 32'd0);

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            check($sformatf("fill_count[%0d]", i), 32'(count), 32'(i));
            check($sformatf("fill_af[%0d]", i), 32'(almost_full), 32'(i >= 14));
            check($sformatf("fill_full[%0d]", i), 32'(full), 32'(i == 16));
            check($sformatf("fill_ae[%0d]", i), 32'(almost_empty), 32'(i <= 2));
            check($sformatf("fill_empty[%0d]", i), 32'(empty), 32'd0);
        end

        // Refused write at full.
        push(8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_unf", 32'(underflow), 32'd0);

        // Drain: data order proves the refused word was not stored.
        for (int i = 1; i <= 16; i++) begin
            read = 1'b1;
            tick();
            check($sformatf("drain_rdata[%0d]", i), 32'(rdata), 32'(i));
            check($sformatf("drain_count[%0d]", i), 32'(count), 32'(16 - i));
            check($sformatf("drain_empty[%0d]", i), 32'(empty), 32'(i == 16));
            check($sformatf("drain_ae[%0d]", i), 32'(almost_empty), 32'((16 - i) <= 2));
        end

        // Read while empty.
        tick();
        read = 1'b0;
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("unf_rdata_hold", 32'(rdata), 32'h10);
        check("unf_ovf_sticky", 32'(overflow), 32'd1);

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_unf", 32'(underflow), 32'd0);

        // New error in the same cycle as clear: set wins.
        clr_err = 1'b1; read = 1'b1;
        tick();
        read = 1'b0;
        check("setwin_unf", 32'(underflow), 32'd1);
        tick();
        clr_err = 1'b0;
        check("clr2_unf", 32'(underflow), 32'd0);

        // Simultaneous access at full.
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        write = 1'b1; read = 1'b1; wdata = 8'hAA;
        tick();
        write = 1'b0; read = 1'b0;
        check("both_full_count", 32'(count), 32'd16);
        check("both_full_full", 32'(full), 32'd1);
        check("both_full_rdata", 32'(rdata), 32'h20);
        check("both_full_ovf", 32'(overflow), 32'd0);

        for (int i = 1; i <= 16; i++) begin
            read = 1'b1;
            tick();
            check($sformatf("both_drain[%0d]", i), 32'(rdata), (i == 16) ? 32'hAA : 32'(8'h20 + i));
        end
        read = 1'b0;
        check("both_drain_empty", 32'(empty), 32'd1);

        // Simultaneous access at count=5, then 40 wrapping transfers.
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        check("five_count", 32'(count), 32'd5);
        write = 1'b1; read = 1'b1; wdata = 8'h45;
        tick();
        check("five_both_count", 32'(count), 32'd5);
        check("five_both_rdata", 32'(rdata), 32'h40);

        for (int k = 0; k < 40; k++) begin
            wdata = 8'(8'h46 + k);
            tick();
            check($sformatf("wrap_rdata[%0d]", k), 32'(rdata), 32'(8'h41 + k));
            check($sformatf("wrap_count[%0d]", k), 32'(count), 32'd5);
        end
        write = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("wrap_tail[%0d]", i), 32'(rdata), 32'(8'h69 + i));
        end
        read = 1'b0;
        check("wrap_empty", 32'(empty), 32'd1);

        // Reset mid-operation with a write pending.
        for (int i = 0; i < 9; i++) push(8'(8'h70 + i));
        check("mid_count9", 32'(count), 32'd9);
        RSTn = 1'b0; write = 1'b1; wdata = 8'h99;
        tick();
        RSTn = 1'b1; write = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        push(8'h33);
        check("mid_post_count", 32'(count), 32'd1);
        read = 1'b1;
        tick();
        read = 1'b0;
        check("mid_first_read", 32'(rdata), 32'h33);
        check("mid_final_empty", 32'(empty), 32'd1);

        // FWFT instance.
        check("fw_rst_empty", 32'(f_empty), 32'd1);
        f_write = 1'b1; f_wdata = 8'h5A;
        tick();
        f_write = 1'b0;
        check("fw_empty_deassert", 32'(f_empty), 32'd0);
        check("fw_head", 32'(f_rdata), 32'h5A);
        check("fw_count1", 32'(f_count), 32'd1);
        tick();
        check("fw_head_hold", 32'(f_rdata), 32'h5A);
        f_read = 1'b1;
        tick();
        f_read = 1'b0;
        check("fw_ack_empty", 32'(f_empty), 32'd1);
        check("fw_ack_count", 32'(f_count), 32'd0);

        f_write = 1'b1; f_wdata = 8'h11;
        tick();
        f_wdata = 8'h22;
        tick();
        f_write = 1'b0;
        check("fw_two_head", 32'(f_rdata), 32'h11);
        f_read = 1'b1;
        tick();
        f_read = 1'b0;
        check("fw_two_next", 32'(f_rdata), 32'h22);
        check("fw_two_count", 32'(f_count), 32'd1);
        check("fw_full", 32'(f_full), 32'd0);
        check("fw_af", 32'(f_almost_full), 32'd0);
        check("fw_ae", 32'(f_almost_empty), 32'd1);
        check("fw_ovf", 32'(f_overflow), 32'd0);
        check("fw_unf", 32'(f_underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
